// File: rtl/phase_pkg.sv
// -----------------------------------------------------------------------------
// phase_pkg
//   Shared definitions for the 5-phase datapath: phase bit indices used by the
//   register file and the other stages, the phase vector width, the sequencer
//   state encoding and a decode helper from state to one-hot phase.
// -----------------------------------------------------------------------------
package phase_pkg;

  localparam int unsigned PHASE_W = 5;

  // One-hot phase vector bit positions
  localparam int unsigned PH_F = 4;
  localparam int unsigned PH_R = 3;
  localparam int unsigned PH_X = 2;
  localparam int unsigned PH_M = 1;
  localparam int unsigned PH_W = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_F    = 3'd1,
    ST_R    = 3'd2,
    ST_X    = 3'd3,
    ST_M    = 3'd4,
    ST_W    = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  // Decode a state to its one-hot phase; IDLE and HALT map to all zeros.
  function automatic logic [PHASE_W-1:0] phase_of(input state_t s);
    logic [PHASE_W-1:0] p;
    p = '0;
    case (s)
      ST_F:    p[PH_F] = 1'b1;
      ST_R:    p[PH_R] = 1'b1;
      ST_X:    p[PH_X] = 1'b1;
      ST_M:    p[PH_M] = 1'b1;
      ST_W:    p[PH_W] = 1'b1;
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/phase_sequencer_rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
//   Registered rising-edge detector. pulse is high for the cycle in which `in`
//   is high and its registered previous value is low.
//   Ports:
//     clk    in  : clock
//     n_rst  in  : asynchronous active-low reset (previous value cleared to 0)
//     in     in  : level input
//     pulse  out : rising-edge indication
// -----------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic n_rst,
  input  logic in,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= in;
    end
  end

  always_comb begin
    pulse = in & ~prev_q;
  end

endmodule

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//   Multicycle control sequencer for the 5-phase datapath (F, R, X, M, W).
//   Stalls F on instruction-memory wait and M on data-memory wait, gates
//   register write-back, strobes the PC advance and counts active cycles and
//   retired instructions. HALT is left only by reset.
//
//   Optional feature macro: PHASE_STEP_EN (adds single-step ports/logic).
//
//   Ports:
//     clk         in      : clock
//     n_rst       in      : asynchronous active-low reset
//     run         in      : continuous-execution enable (level)
//     imem_ready  in      : instruction fetch complete (sampled in F)
//     halt        in      : decoded halt instruction (sampled in X)
//     dmem_req    in      : instruction accesses data memory (sampled in X)
//     dmem_ready  in      : data access complete (sampled in M)
//     wb_en       in      : instruction writes a register (sampled in X)
//     step_mode   in      : single-step enable      (PHASE_STEP_EN only)
//     step        in      : step release, rising edge (PHASE_STEP_EN only)
//     phase       out [5] : one-hot phase, bit4=F .. bit0=W, 0 in IDLE/HALT
//     rf_we       out     : register-file write enable
//     pc_en       out     : one-cycle PC advance strobe
//     busy        out     : high in F/R/X/M/W
//     halted      out     : high in HALT
//     cycle_cnt   out [32]: active-cycle counter (wraps)
//     instr_cnt   out [32]: retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module phase_sequencer
  import phase_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               run,
  input  logic               imem_ready,
  input  logic               halt,
  input  logic               dmem_req,
  input  logic               dmem_ready,
  input  logic               wb_en,
`ifdef PHASE_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic [PHASE_W-1:0] phase,
  output logic               rf_we,
  output logic               pc_en,
  output logic               busy,
  output logic               halted,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt
);

  state_t state_q;
  state_t state_d;

  logic req_l;
  logic wb_l;
  logic halt_l;

  // idle_go : condition to leave IDLE for F
  // w_cont  : condition to go from W straight into the next F
  logic idle_go;
  logic w_cont;

`ifdef PHASE_STEP_EN
  logic step_pulse;

  rise_detect u_step_rise (
    .clk   (clk),
    .n_rst (n_rst),
    .in    (step),
    .pulse (step_pulse)
  );

  // In single-step mode only a step edge releases an instruction, and every
  // instruction returns to IDLE after W.
  always_comb begin
    idle_go = step_mode ? step_pulse : run;
    w_cont  = run & ~step_mode;
  end
`else
  always_comb begin
    idle_go = run;
    w_cont  = run;
  end
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (idle_go) state_d = ST_F;
      ST_F:    if (imem_ready) state_d = ST_R;
      ST_R:    state_d = ST_X;
      ST_X:    state_d = ST_M;
      ST_M:    if (!req_l || dmem_ready) state_d = ST_W;
      ST_W: begin
        if (halt_l) begin
          state_d = ST_HALT;
        end else if (w_cont) begin
          state_d = ST_F;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    phase  = phase_of(state_q);
    pc_en  = phase[PH_W];
    rf_we  = phase[PH_W] & wb_l;
    busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);
    halted = (state_q == ST_HALT);
  end

  // ---------------------------------------------------------------------------
  // Per-instruction attributes captured in X
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      req_l  <= 1'b0;
      wb_l   <= 1'b0;
      halt_l <= 1'b0;
    end else if (state_q == ST_X) begin
      req_l  <= dmem_req;
      wb_l   <= wb_en;
      halt_l <= halt;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, both wrap modulo 2^32
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (state_q == ST_W) begin
        instr_cnt <= instr_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
//   Self-checking bench for phase_sequencer: directed scenarios followed by
//   randomized stimulus, checked every cycle against a behavioural model that
//   tracks the current phase as a position 0..4 within the instruction.
//   Compile with PHASE_STEP_EN defined to exercise the single-step feature.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

  logic        clk;
  logic        n_rst;
  logic        run;
  logic        imem_ready;
  logic        halt;
  logic        dmem_req;
  logic        dmem_ready;
  logic        wb_en;
  logic        step_mode;
  logic        step;
  logic [4:0]  phase;
  logic        rf_we;
  logic        pc_en;
  logic        busy;
  logic        halted;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  int unsigned checks;
  int unsigned errors;

  // Model: pos = -1 idle, 0..4 = F,R,X,M,W, 5 = halted
  int          m_pos;
  bit          m_req;
  bit          m_wb;
  bit          m_halt;
  bit          m_step_prev;
  logic [31:0] m_cyc;
  logic [31:0] m_ins;

  phase_sequencer dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .run        (run),
    .imem_ready (imem_ready),
    .halt       (halt),
    .dmem_req   (dmem_req),
    .dmem_ready (dmem_ready),
    .wb_en      (wb_en),
`ifdef PHASE_STEP_EN
    .step_mode  (step_mode),
    .step       (step),
`endif
    .phase      (phase),
    .rf_we      (rf_we),
    .pc_en      (pc_en),
    .busy       (busy),
    .halted     (halted),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos       = -1;
    m_req       = 1'b0;
    m_wb        = 1'b0;
    m_halt      = 1'b0;
    m_step_prev = 1'b0;
    m_cyc       = '0;
    m_ins       = '0;
  endtask

  // One clock edge of the reference behaviour, using the inputs now applied.
  task automatic model_edge();
    bit go;
    bit sm;
`ifdef PHASE_STEP_EN
    sm = step_mode;
    go = sm ? (step && !m_step_prev) : run;
`else
    sm = 1'b0;
    go = run;
`endif
    if (m_pos >= 0 && m_pos <= 4) m_cyc = m_cyc + 1;
    if (m_pos == 4) m_ins = m_ins + 1;
    case (m_pos)
      -1: if (go) m_pos = 0;
      0:  if (imem_ready) m_pos = 1;
      1:  m_pos = 2;
      2: begin
        m_req  = dmem_req;
        m_wb   = wb_en;
        m_halt = halt;
        m_pos  = 3;
      end
      3:  if (!m_req || dmem_ready) m_pos = 4;
      4: begin
        if (m_halt) m_pos = 5;
        else if (run && !sm) m_pos = 0;
        else m_pos = -1;
      end
      default: m_pos = 5;
    endcase
    m_step_prev = step;
  endtask

  task automatic check_outputs();
    logic [4:0] exp_ph;
    bit         in_instr;
    in_instr = (m_pos >= 0) && (m_pos <= 4);
    exp_ph   = in_instr ? (5'b10000 >> m_pos) : 5'b00000;
    check("phase",     {27'd0, phase},  {27'd0, exp_ph});
    check("rf_we",     {31'd0, rf_we},  {31'd0, (m_pos == 4) && m_wb});
    check("pc_en",     {31'd0, pc_en},  {31'd0, (m_pos == 4)});
    check("busy",      {31'd0, busy},   {31'd0, in_instr});
    check("halted",    {31'd0, halted}, {31'd0, (m_pos == 5)});
    check("cycle_cnt", cycle_cnt, m_cyc);
    check("instr_cnt", instr_cnt, m_ins);
  endtask

  // Apply inputs away from the edge, advance one clock, then check.
  task automatic tick(input bit r, input bit im, input bit h, input bit rq,
                      input bit dr, input bit wb);
    run        = r;
    imem_ready = im;
    halt       = h;
    dmem_req   = rq;
    dmem_ready = dr;
    wb_en      = wb;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Asynchronous reset asserted between edges, released on a falling edge.
  task automatic do_reset();
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    check_outputs();
    run = 1'b0; imem_ready = 1'b0; halt = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0; wb_en = 1'b0;
    step = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    logic [31:0] c0;
    logic [31:0] i0;
    int          pc_pulses;
    int          halt_cycles;

    checks = 0;
    errors = 0;
    n_rst = 1'b0;
    run = 1'b0; imem_ready = 1'b0; halt = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0; wb_en = 1'b0;
    step_mode = 1'b0; step = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Three back-to-back instructions with no waits.
    for (int i = 0; i < 16; i++) tick(1, 1, 0, 0, 0, 1);
    check("seq3_cycles", cycle_cnt, 32'd15);
    check("seq3_instr",  instr_cnt, 32'd3);
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, 0, 1);
    check("seq3_idle", {31'd0, busy}, 32'd0);

    // Two F waits and three M waits: 10-cycle instruction, one PC pulse.
    do_reset();
    tick(1, 0, 0, 0, 0, 0);
    c0 = cycle_cnt; i0 = instr_cnt; pc_pulses = 0;
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 0, 0);
      if (pc_en) pc_pulses++;
    end
    tick(0, 0, 0, 0, 1, 0);
    if (pc_en) pc_pulses++;
    tick(0, 0, 0, 0, 0, 0);
    if (pc_en) pc_pulses++;
    check("wait_cycles", cycle_cnt - c0, 32'd10);
    check("wait_instr",  instr_cnt - i0, 32'd1);
    check("wait_pc_pulses", pc_pulses, 32'd1);

    // Halt instruction: counted, then HALT unaffected by run.
    do_reset();
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    check("halt_flag",  {31'd0, halted}, 32'd1);
    check("halt_instr", instr_cnt, 32'd1);
    for (int i = 0; i < 6; i++) tick(i[0], 1, 0, 0, 1, 0);
    check("halt_stays", {31'd0, halted}, 32'd1);
    do_reset();
    check("halt_cleared", {31'd0, halted}, 32'd0);

    // run dropped in R: finishes through W then idles.
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 1);
    check("drop_busy",  {31'd0, busy}, 32'd0);
    check("drop_instr", instr_cnt, 32'd1);

    // Reset while in M with write-back latched.
    do_reset();
    tick(1, 1, 0, 0, 0, 1);
    tick(0, 1, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 0, 1);
    do_reset();
    check("mrst_rf_we", {31'd0, rf_we}, 32'd0);
    check("mrst_instr", instr_cnt, 32'd0);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 1, 1);

`ifdef PHASE_STEP_EN
    // Single-step: one instruction per step edge, holding step gives one.
    step_mode = 1'b1;
    step = 1'b0;
    tick(1, 1, 0, 0, 0, 1);
    step = 1'b1;
    for (int i = 0; i < 12; i++) tick(1, 1, 0, 0, 0, 1);
    check("step_hold_instr", instr_cnt, 32'd1);
    check("step_hold_idle",  {31'd0, busy}, 32'd0);
    step = 1'b0;
    tick(1, 1, 0, 0, 0, 1);
    step = 1'b1;
    for (int i = 0; i < 6; i++) tick(1, 1, 0, 0, 0, 1);
    check("step_second", instr_cnt, 32'd2);
    step_mode = 1'b0;
    step = 1'b0;
`endif

    // Randomized stimulus.
    halt_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
`ifdef PHASE_STEP_EN
      if ($urandom_range(0, 49) == 0) step_mode = $urandom_range(0, 1) != 0;
      step = $urandom_range(0, 3) == 0;
`endif
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 1) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0);
      if (m_pos == 5) halt_cycles++;
      if (halt_cycles > 4 || $urandom_range(0, 399) == 0) begin
        halt_cycles = 0;
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Multicycle control sequencer for the 5-phase datapath. Generates the one-hot `phase` vector (F, R, X, M, W) consumed by the register file and the other datapath stages. Stalls F on instruction-memory wait and M on data-memory wait, gates register write-back, advances the PC and counts cycles and retired instructions. Sits at the top of the datapath, beside the instruction decoder.

## Interface
- No parameters; all widths are fixed.
- `clk` in 1: clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `run` in 1: level; enables continuous execution.
- `imem_ready` in 1: instruction fetch complete; sampled in F.
- `halt` in 1: decoded halt instruction; sampled in X.
- `dmem_req` in 1: instruction accesses data memory; sampled in X.
- `dmem_ready` in 1: data access complete; sampled in M.
- `wb_en` in 1: instruction writes a register; sampled in X.
- `step_mode` in 1: single-step enable. Present only with `PHASE_STEP_EN`.
- `step` in 1: level; each rising edge releases one instruction. Present only with `PHASE_STEP_EN`.
- `phase` out 5: one-hot; bit4=F, bit3=R, bit2=X, bit1=M, bit0=W.
- `rf_we` out 1: register-file write enable.
- `pc_en` out 1: one-cycle PC advance strobe.
- `busy` out 1: high in F/R/X/M/W.
- `halted` out 1: high in HALT.
- `cycle_cnt` out 32: active-cycle counter.
- `instr_cnt` out 32: retired-instruction counter.

## Operation
- States: IDLE, F, R, X, M, W, HALT. `phase` is 0 in IDLE and HALT; otherwise exactly one bit is set.
- State transitions:
  - IDLE -> F when `run`=1.
  - F -> R when `imem_ready`=1; otherwise stay in F.
  - R -> X unconditionally.
  - X -> M unconditionally. X latches `dmem_req`, `wb_en` and `halt` into `req_l`, `wb_l`, `halt_l`.
  - M -> W when `req_l`=0 or `dmem_ready`=1; otherwise stay in M.
  - W -> HALT if `halt_l`; else -> F if `run`; else -> IDLE.
  - HALT is left only by reset.
- Outputs:
  - `rf_we` = phase[W] & `wb_l`.
  - `pc_en` = phase[W].
  - `busy` = (state not IDLE/HALT).
- Counters:
  - `instr_cnt` increments by 1 in every W cycle. A halt instruction is counted.
  - `cycle_cnt` increments in every cycle while `busy`=1.
  - Both wrap modulo 2^32 with no saturation and no flag.
- Inputs outside their sampling phase are ignored. `run` dropping mid-instruction does not abort the instruction; the sequencer finishes at W and then goes to IDLE.

## Timing
- Reset values: state IDLE, `phase`=5'b00000, `rf_we`=0, `pc_en`=0, `busy`=0, `halted`=0, `cycle_cnt`=0, `instr_cnt`=0, latches 0.
- State, counters and latches are registered. `phase` and all strobes are decoded from registered state only, so they are glitch-free and carry no input-to-output combinational path.
- Minimum instruction latency is 5 cycles (F,R,X,M,W). Each F wait adds 1 cycle; each M wait with `req_l`=1 adds 1 cycle.
- With `run` held high, the F of the next instruction follows W back-to-back.
- `run` rising in IDLE: F appears in the next cycle.
- Reset asserted mid-instruction: everything returns to reset values immediately. No W is issued, so no register write occurs.

## Configuration
- Macro: `PHASE_STEP_EN`.
- Defined: `step_mode` and `step` ports exist.
  - With `step_mode`=1, W always goes to IDLE regardless of `run`.
  - IDLE -> F only on a rising edge of `step`. The edge is detected internally with a registered previous value, reset to 0.
  - With `step_mode`=0, behaviour is as without the macro.
- Undefined: the ports and edge-detect logic are absent; only `run` controls IDLE exit.

## Structure
- Shared package `phase_pkg` holds:
  - phase bit indices PH_F=4, PH_R=3, PH_X=2, PH_M=1, PH_W=0;
  - the state encoding;
  - the 5-bit phase width.
- The register file and other stages import the same indices.
- One sub-module: `rise_detect` (clk, n_rst, in, pulse), instantiated only under `PHASE_STEP_EN`.

## Test plan
- Reset, then `run`=1, `imem_ready`=1, `dmem_req`=0, `wb_en`=1 for 3 instructions -> `phase` cycles 10000,01000,00100,00010,00001 three times; `rf_we`=1 on each W; `instr_cnt`=3; `cycle_cnt`=15.
- `imem_ready` low for 2 cycles in F, then `dmem_req`=1 with `dmem_ready` low for 3 cycles in M -> instruction takes 10 cycles; `pc_en` exactly one pulse.
- `halt`=1 sampled in X -> M, W (`instr_cnt`+1), then HALT with `halted`=1, `phase`=0. Toggling `run` has no effect; `n_rst` clears it.
- `run` dropped during R -> instruction completes through W, then IDLE with `busy`=0.
- `n_rst` pulsed while in M with `wb_en` latched -> no `rf_we` pulse; all outputs at reset values.
- `PHASE_STEP_EN` with `step_mode`=1, `run`=1 -> each `step` rising edge yields exactly one 5-phase instruction; holding `step` high yields only one.
